// File: rtl/shift_seq_ctrl.sv
// Serial shift-transfer sequencer: accepts a parallel word, shifts L bits out on serial_out_o
// while capturing serial_in_i on the same edges, then strobes the received word for one cycle.
module shift_seq_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic [CNT_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             serial_in_i,
    output logic             serial_out_o,
    output logic             shift_en_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] eff_len;
    logic [WIDTH-1:0] tx_load, tx_adv, rx_samp;
    logic             tx_bit;
    logic             load_en, shift_adv;

    // Zero and oversize lengths both mean a full-width transfer.
    always_comb begin
        eff_len = len_i;
        if (len_i == '0 || len_i > WIDTH_C) begin
            eff_len = WIDTH_C;
        end
    end

    generate
        if (LSB_FIRST) begin : g_lsb
            // One-hot pointer places the k-th received bit at position k.
            logic [WIDTH-1:0] wr_sel_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_sel_q <= '0;
                end else if (load_en) begin
                    wr_sel_q <= WIDTH'(1);
                end else if (shift_adv) begin
                    wr_sel_q <= wr_sel_q << 1;
                end
            end

            assign tx_load = tx_data_i;
            assign tx_adv  = tx_sr_q >> 1;
            assign tx_bit  = tx_sr_q[0];
            assign rx_samp = serial_in_i ? (rx_sr_q | wr_sel_q) : rx_sr_q;
        end else begin : g_msb
            // Left-align the active field so the outgoing bit is always the top bit.
            assign tx_load = tx_data_i << (WIDTH_C - eff_len);
            assign tx_adv  = tx_sr_q << 1;
            assign tx_bit  = tx_sr_q[WIDTH-1];
            assign rx_samp = {rx_sr_q[WIDTH-2:0], serial_in_i};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        load_en   = 1'b0;
        shift_adv = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid_i) begin
                    load_en = 1'b1;
                    tx_sr_d = tx_load;
                    rx_sr_d = '0;
                    cnt_d   = eff_len;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Abort wins even on the final bit, so rx_data_q is never touched.
                if (abort_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    shift_adv = 1'b1;
                    tx_sr_d   = tx_adv;
                    rx_sr_d   = rx_samp;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rx_data_d = rx_samp;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready_o   = (state_q == S_IDLE);
    assign shift_en_o   = (state_q == S_SHIFT);
    assign busy_o       = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign rx_valid_o   = (state_q == S_DONE);
    assign serial_out_o = (state_q == S_SHIFT) && tx_bit;
    assign rx_data_o    = rx_data_q;

endmodule
